// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC request controller: FSM state encoding and
// the default watchdog limit.
package cordic_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StWait  = 3'd2,
        StAck   = 3'd3,
        StResp  = 3'd4
    } ctrl_state_e;

    localparam int unsigned DefaultTimeout = 200;

endpackage

// File: rtl/cordic_watchdog_cnt.sv
// Saturating cycle counter with synchronous clear and enable; hit flags the last
// cycle before the watchdog limit. TIMEOUT = 0 disables hit.
module cordic_watchdog_cnt
    import cordic_ctrl_pkg::*;
#(
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned HitVal = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    // A limit the counter cannot represent would alias after truncation, so it never hits.
    localparam bit Reachable = (TIMEOUT != 0) &&
                               ((TO_W >= 32) || (HitVal < (32'd1 << TO_W)));
    localparam logic [TO_W-1:0] HitCnt = TO_W'(HitVal);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign hit = Reachable && (cnt_q == HitCnt);

endmodule

// File: rtl/cordic_request_ctrl.sv
// Initiator-side controller for the sine/cosine CORDIC core: accepts one request,
// drives the core start/ack handshake, and returns the captured result downstream.
module cordic_request_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic         clk,
    input  logic         rst,
    // upstream request
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_angle,
    input  logic         req_op,
    input  logic [1:0]   req_region,
    // downstream response
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_ovf,
    output logic         rsp_udf,
    output logic         rsp_timeout,
    // CORDIC core side
    output logic         beg_fsm_cordic,
    output logic         ack_cordic,
    output logic         operation,
    output logic [W-1:0] data_in,
    output logic [1:0]   shift_region_flag,
    input  logic         ready_cordic,
    input  logic [W-1:0] data_output,
    input  logic         overflow_flag,
    input  logic         underflow_flag
);

    ctrl_state_e state_q;
    logic        wd_hit;

    cordic_watchdog_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (state_q == StStart),
        .en  (state_q == StWait),
        .hit (wd_hit)
    );

    assign req_ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= StIdle;
            beg_fsm_cordic    <= 1'b0;
            ack_cordic        <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_timeout       <= 1'b0;
            rsp_ovf           <= 1'b0;
            rsp_udf           <= 1'b0;
            rsp_data          <= '0;
            data_in           <= '0;
            operation         <= 1'b0;
            shift_region_flag <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        data_in           <= req_angle;
                        operation         <= req_op;
                        shift_region_flag <= req_region;
                        beg_fsm_cordic    <= 1'b1;
                        state_q           <= StStart;
                    end
                end
                StStart: begin
                    beg_fsm_cordic <= 1'b0;
                    state_q        <= StWait;
                end
                StWait: begin
                    // A genuine result takes priority over a watchdog expiring in the same cycle.
                    if (ready_cordic) begin
                        rsp_data    <= data_output;
                        rsp_ovf     <= overflow_flag;
                        rsp_udf     <= underflow_flag;
                        rsp_timeout <= 1'b0;
                        ack_cordic  <= 1'b1;
                        state_q     <= StAck;
                    end else if (wd_hit) begin
                        rsp_data    <= '0;
                        rsp_ovf     <= 1'b0;
                        rsp_udf     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        ack_cordic  <= 1'b1;
                        state_q     <= StAck;
                    end
                end
                StAck: begin
                    if (!ready_cordic) begin
                        ack_cordic <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    beg_fsm_cordic <= 1'b0;
                    ack_cordic     <= 1'b0;
                    rsp_valid      <= 1'b0;
                    state_q        <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_request_ctrl.sv
// Directed bench for cordic_request_ctrl: one instance with the default watchdog,
// one with TIMEOUT = 20 for the watchdog and tie-break scenarios.
module tb_cordic_request_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_angle;
    logic        req_op;
    logic [1:0]  req_region;
    logic        rsp_ready;
    logic        ready_cordic;
    logic [31:0] data_output;
    logic        overflow_flag;
    logic        underflow_flag;

    logic        a_req_ready, a_rsp_valid, a_rsp_ovf, a_rsp_udf, a_rsp_timeout;
    logic        a_beg, a_ack, a_operation;
    logic [31:0] a_rsp_data, a_data_in;
    logic [1:0]  a_region;

    logic        b_req_ready, b_rsp_valid, b_rsp_ovf, b_rsp_udf, b_rsp_timeout;
    logic        b_beg, b_ack, b_operation;
    logic [31:0] b_rsp_data, b_data_in;
    logic [1:0]  b_region;

    int n_checks;
    int n_errors;

    cordic_request_ctrl dut_a (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (a_req_ready),
        .req_angle         (req_angle),
        .req_op            (req_op),
        .req_region        (req_region),
        .rsp_valid         (a_rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (a_rsp_data),
        .rsp_ovf           (a_rsp_ovf),
        .rsp_udf           (a_rsp_udf),
        .rsp_timeout       (a_rsp_timeout),
        .beg_fsm_cordic    (a_beg),
        .ack_cordic        (a_ack),
        .operation         (a_operation),
        .data_in           (a_data_in),
        .shift_region_flag (a_region),
        .ready_cordic      (ready_cordic),
        .data_output       (data_output),
        .overflow_flag     (overflow_flag),
        .underflow_flag    (underflow_flag)
    );

    cordic_request_ctrl #(
        .TIMEOUT (20)
    ) dut_b (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (b_req_ready),
        .req_angle         (req_angle),
        .req_op            (req_op),
        .req_region        (req_region),
        .rsp_valid         (b_rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (b_rsp_data),
        .rsp_ovf           (b_rsp_ovf),
        .rsp_udf           (b_rsp_udf),
        .rsp_timeout       (b_rsp_timeout),
        .beg_fsm_cordic    (b_beg),
        .ack_cordic        (b_ack),
        .operation         (b_operation),
        .data_in           (b_data_in),
        .shift_region_flag (b_region),
        .ready_cordic      (ready_cordic),
        .data_output       (data_output),
        .overflow_flag     (overflow_flag),
        .underflow_flag    (underflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns in the cycle after the accept.
    task automatic issue(input logic [31:0] angle, input logic op, input logic [1:0] region);
        req_valid  = 1'b1;
        req_angle  = angle;
        req_op     = op;
        req_region = region;
        tick();
        req_valid  = 1'b0;
    endtask

    // Core model: ready held for 'hold' cycles, then dropped; returns in the first RESP cycle.
    task automatic core_respond(input string tag, input logic [31:0] data, input logic ovf,
                                input logic udf, input int hold);
        ready_cordic   = 1'b1;
        data_output    = data;
        overflow_flag  = ovf;
        underflow_flag = udf;
        tick();
        check_eq({tag, "_ack_rise"}, a_ack, 1);
        for (int i = 1; i < hold; i++) begin
            tick();
            check_eq({tag, "_ack_held"}, a_ack, 1);
        end
        ready_cordic = 1'b0;
        tick();
        check_eq({tag, "_rsp_valid"}, a_rsp_valid, 1);
        check_eq({tag, "_ack_drop"}, a_ack, 0);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen_valid;
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b0;
        req_valid      = 1'b0;
        req_angle      = '0;
        req_op         = 1'b0;
        req_region     = 2'b00;
        rsp_ready      = 1'b0;
        ready_cordic   = 1'b0;
        data_output    = '0;
        overflow_flag  = 1'b0;
        underflow_flag = 1'b0;

        repeat (10) tick();
        check_eq("rst_req_ready", a_req_ready, 1);
        check_eq("rst_beg", a_beg, 0);
        check_eq("rst_ack", a_ack, 0);
        check_eq("rst_rsp_valid", a_rsp_valid, 0);
        check_eq("rst_rsp_data", a_rsp_data, 0);
        check_eq("rst_data_in", a_data_in, 0);
        check_eq("rst_timeout", a_rsp_timeout, 0);
        rst = 1'b1;

        // nominal sine request
        issue(32'h3f91361e, 1'b1, 2'b00);
        check_eq("nom_beg_pulse", a_beg, 1);
        check_eq("nom_req_ready_low", a_req_ready, 0);
        check_eq("nom_data_in", a_data_in, 32'h3f91361e);
        check_eq("nom_operation", a_operation, 1);
        check_eq("nom_region", a_region, 0);
        tick();
        check_eq("nom_beg_single", a_beg, 0);
        repeat (28) tick();
        check_eq("nom_no_early_ack", a_ack, 0);
        core_respond("nom", 32'h3F680000, 1'b0, 1'b0, 3);
        check_eq("nom_rsp_data", a_rsp_data, 32'h3F680000);
        check_eq("nom_rsp_timeout", a_rsp_timeout, 0);
        check_eq("nom_rsp_ovf", a_rsp_ovf, 0);
        finish_rsp();
        check_eq("nom_rsp_done", a_rsp_valid, 0);
        check_eq("nom_idle_ready", a_req_ready, 1);

        // overflow flag
        issue(32'h42c80000, 1'b0, 2'b11);
        check_eq("ovf_operation", a_operation, 0);
        check_eq("ovf_region", a_region, 3);
        repeat (4) tick();
        core_respond("ovf", 32'h7F800000, 1'b1, 1'b0, 1);
        check_eq("ovf_rsp_data", a_rsp_data, 32'h7F800000);
        check_eq("ovf_rsp_ovf", a_rsp_ovf, 1);
        check_eq("ovf_rsp_udf", a_rsp_udf, 0);
        finish_rsp();

        // underflow flag
        issue(32'h3a83126f, 1'b1, 2'b01);
        repeat (3) tick();
        core_respond("udf", 32'h00000001, 1'b0, 1'b1, 1);
        check_eq("udf_rsp_data", a_rsp_data, 32'h00000001);
        check_eq("udf_rsp_ovf", a_rsp_ovf, 0);
        check_eq("udf_rsp_udf", a_rsp_udf, 1);
        finish_rsp();

        // backpressure, then back-to-back accept of the request waiting upstream
        issue(32'h3f000000, 1'b1, 2'b10);
        repeat (2) tick();
        core_respond("bp", 32'h3ef4ff53, 1'b0, 1'b0, 1);
        req_valid  = 1'b1;
        req_angle  = 32'h40490fdb;
        req_op     = 1'b0;
        req_region = 2'b01;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("bp_rsp_valid", a_rsp_valid, 1);
            check_eq("bp_rsp_data", a_rsp_data, 32'h3ef4ff53);
            check_eq("bp_req_ready", a_req_ready, 0);
            check_eq("bp_data_in_held", a_data_in, 32'h3f000000);
            check_eq("bp_no_beg", a_beg, 0);
        end
        finish_rsp();
        check_eq("bp_rsp_done", a_rsp_valid, 0);
        check_eq("bp_idle_ready", a_req_ready, 1);
        check_eq("bp_not_yet_beg", a_beg, 0);
        tick();
        req_valid = 1'b0;
        check_eq("b2b_beg", a_beg, 1);
        check_eq("b2b_data_in", a_data_in, 32'h40490fdb);
        check_eq("b2b_operation", a_operation, 0);
        check_eq("b2b_region", a_region, 1);

        // reset while in WAIT
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rstw_req_ready", a_req_ready, 1);
        check_eq("rstw_beg", a_beg, 0);
        check_eq("rstw_ack", a_ack, 0);
        check_eq("rstw_rsp_valid", a_rsp_valid, 0);
        check_eq("rstw_rsp_data", a_rsp_data, 0);
        check_eq("rstw_data_in", a_data_in, 0);
        check_eq("rstw_region", a_region, 0);
        rst          = 1'b1;
        ready_cordic = 1'b1;
        data_output  = 32'h12345678;
        seen_valid   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) ready_cordic = 1'b0;
            tick();
            if (a_rsp_valid) seen_valid = 1'b1;
        end
        check_eq("rstw_no_rsp", seen_valid, 0);

        // watchdog on the TIMEOUT = 20 instance
        data_output    = 32'hDEADBEEF;
        overflow_flag  = 1'b1;
        underflow_flag = 1'b1;
        issue(32'h3f800000, 1'b1, 2'b00);
        n = 0;
        while (b_ack !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        // START plus 20 WAIT cycles precede the ACK cycle
        check_eq("to_wait_len", n, 21);
        tick();
        check_eq("to_ack_single", b_ack, 0);
        check_eq("to_rsp_valid", b_rsp_valid, 1);
        check_eq("to_rsp_timeout", b_rsp_timeout, 1);
        check_eq("to_rsp_data", b_rsp_data, 0);
        check_eq("to_rsp_ovf", b_rsp_ovf, 0);
        check_eq("to_rsp_udf", b_rsp_udf, 0);
        finish_rsp();
        check_eq("to_idle_ready", b_req_ready, 1);
        overflow_flag  = 1'b0;
        underflow_flag = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;

        // ready arrives on the same edge the watchdog would fire
        issue(32'hbf800000, 1'b0, 2'b11);
        repeat (20) tick();
        check_eq("sim_no_early_ack", b_ack, 0);
        ready_cordic = 1'b1;
        data_output  = 32'h3f2b5a12;
        tick();
        check_eq("sim_ack", b_ack, 1);
        ready_cordic = 1'b0;
        tick();
        check_eq("sim_rsp_valid", b_rsp_valid, 1);
        check_eq("sim_rsp_timeout", b_rsp_timeout, 0);
        check_eq("sim_rsp_data", b_rsp_data, 32'h3f2b5a12);
        finish_rsp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
